sev_seg_scan_driver: RTL and testbench

Time-multiplexed driver for a bank of NUM_DIGITS common-anode seven-segment digits.
It is the parametrised successor of the single-digit decoder: full hex decode (0-F), per-digit blanking, decimal points, optional leading-zero blanking, and a coherent shadow load.
It sits between the datapath (counters, ticket numbers, queue state) and the board display pins.
One digit is lit at a time; the block scans all digits at a rate set by a clock prescaler.

---
 rtl/sev_seg_pkg.sv | 22 ++
 rtl/sev_seg_hex_lut.sv | 11 +
 rtl/sev_seg_scan_driver.sv | 124 ++++++++++++
 tb/tb_sev_seg_scan_driver.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/sev_seg_pkg.sv
// Shared constants for the seven-segment scan driver: active-low glyph table
// (bit6 = g ... bit0 = a) and a width helper.
package sev_seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_CODES [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // ceil(log2(n)), but never below 1 so single-entry counters still get a bit
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/sev_seg_hex_lut.sv
// Hex nibble to active-low seven-segment pattern; every input has a code.
module sev_seg_hex_lut
  import sev_seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = SEG_CODES[nib];

endmodule

// File: rtl/sev_seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with shadow load,
// per-digit blanking, decimal points and leading-zero blanking.
module sev_seg_scan_driver
  import sev_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [4*NUM_DIGITS-1:0]               digits_in,
  input  logic [NUM_DIGITS-1:0]                 dp_in,
  input  logic [NUM_DIGITS-1:0]                 digit_en,
  input  logic                                  lzb_en,
  input  logic                                  load,
  output logic [6:0]                            seg,
  output logic                                  dp,
  output logic [NUM_DIGITS-1:0]                 an,
  output logic [clog2_min1(NUM_DIGITS)-1:0]     scan_idx
);

  localparam int IDX_W = clog2_min1(NUM_DIGITS);
  localparam int PW    = clog2_min1(CLK_DIV);
  localparam logic [PW-1:0]    PRE_MAX = PW'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

  logic [PW-1:0]                presc_q, presc_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [NUM_DIGITS-1:0][3:0]   dig_q, dig_d;
  logic [NUM_DIGITS-1:0]        dp_sh_q, dp_sh_d;
  logic [NUM_DIGITS-1:0]        en_sh_q, en_sh_d;
  logic                         lzb_q, lzb_d;
  logic [6:0]                   seg_q, seg_d;
  logic                         dp_q, dp_d;
  logic [NUM_DIGITS-1:0]        an_q, an_d;
  logic [IDX_W-1:0]             sidx_q, sidx_d;

  logic                         tick;
  logic [3:0]                   cur_nib;
  logic [6:0]                   cur_code;
  logic [NUM_DIGITS-1:0]        lz_blank;
  logic                         zero_run;
  logic                         blank;

  assign cur_nib = dig_q[idx_q];

  sev_seg_hex_lut u_lut (
    .nib (cur_nib),
    .seg (cur_code)
  );

  always_comb begin
    tick    = (presc_q == PRE_MAX);
    presc_d = tick ? '0 : presc_q + 1'b1;
    idx_d   = idx_q;
    if (tick) idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;

    dig_d   = dig_q;
    dp_sh_d = dp_sh_q;
    en_sh_d = en_sh_q;
    lzb_d   = lzb_q;
    if (load) begin
      dig_d   = digits_in;
      dp_sh_d = dp_in;
      en_sh_d = digit_en;
      lzb_d   = lzb_en;
    end
  end

  // Walk down from the MSD; a digit is a leading zero while every nibble
  // from it upward is zero. Digit 0 is always shown.
  always_comb begin
    zero_run = 1'b1;
    lz_blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run    = zero_run & (dig_q[i] == 4'd0);
      lz_blank[i] = lzb_q & zero_run;
    end
  end

  always_comb begin
    blank  = !en_sh_q[idx_q] || lz_blank[idx_q];
    seg_d  = blank ? SEG_BLANK : cur_code;
    dp_d   = !(dp_sh_q[idx_q] && !blank);
    an_d   = '1;
    if (!blank) an_d[idx_q] = 1'b0;
    sidx_d = idx_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= '0;
      dig_q   <= '0;
      dp_sh_q <= '0;
      en_sh_q <= '0;
      lzb_q   <= 1'b0;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
      an_q    <= '1;
      sidx_q  <= '0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      dig_q   <= dig_d;
      dp_sh_q <= dp_sh_d;
      en_sh_q <= en_sh_d;
      lzb_q   <= lzb_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
      sidx_q  <= sidx_d;
    end
  end

  // Registers hold active-low values; polarity options only flip the pins.
  assign seg      = SEG_ACTIVE_LOW ? seg_q : ~seg_q;
  assign dp       = SEG_ACTIVE_LOW ? dp_q  : ~dp_q;
  assign an       = AN_ACTIVE_LOW  ? an_q  : ~an_q;
  assign scan_idx = sidx_q;

endmodule

// File: tb/tb_sev_seg_scan_driver.sv
// Scoreboard bench for sev_seg_scan_driver: driver queues expected per-edge
// outputs from directed loads, monitor compares on the falling edge.
module tb_sev_seg_scan_driver;

  localparam int ND = 4;
  localparam int CD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  digit_en = '0;
  logic        lzb_en = 1'b0;
  logic        load = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [1:0]  scan_idx;

  sev_seg_scan_driver #(
    .NUM_DIGITS     (ND),
    .CLK_DIV        (CD),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .digits_in (digits_in),
    .dp_in     (dp_in),
    .digit_en  (digit_en),
    .lzb_en    (lzb_en),
    .load      (load),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .scan_idx  (scan_idx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int unsigned cyc;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic [1:0]  idx;
  } exp_t;

  // Hand-copied g..a active-low glyphs for 0..F
  logic [6:0] hex_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_vec = 0;
  int          n_bad = 0;
  int unsigned cyc = 0;

  int          k = 0;
  logic [15:0] sh_val = '0;
  logic [3:0]  sh_dp = '0;
  logic [3:0]  sh_lit = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      mon_e = sb.pop_front();
      n_vec++;
      if (seg !== mon_e.seg || dp !== mon_e.dp || an !== mon_e.an || scan_idx !== mon_e.idx) begin
        n_bad++;
        $display("FAIL out@cyc%0d: got seg=%b dp=%b an=%b idx=%0d, want seg=%b dp=%b an=%b idx=%0d",
                 cyc, seg, dp, an, scan_idx, mon_e.seg, mon_e.dp, mon_e.an, mon_e.idx);
      end
    end
  end

  // One clock edge: drive inputs, queue what the outputs must show after it.
  // Non-load cycles scramble every input so shadow isolation is always tested.
  task automatic step(input logic rst, input logic ld, input logic [15:0] v,
                      input logic [3:0] d, input logic [3:0] e, input logic lz,
                      input logic [3:0] lit);
    exp_t x;
    int   idx;
    rst_n = !rst;
    load  = ld;
    if (ld) begin
      digits_in = v; dp_in = d; digit_en = e; lzb_en = lz;
    end else begin
      digits_in = 16'($urandom); dp_in = 4'($urandom);
      digit_en  = 4'($urandom);  lzb_en = 1'($urandom);
    end
    x.cyc = cyc + 1;
    if (rst) begin
      x.seg = 7'b1111111; x.dp = 1'b1; x.an = 4'b1111; x.idx = 2'd0;
    end else begin
      idx   = (k / CD) % ND;
      x.idx = 2'(idx);
      if (sh_lit[idx]) begin
        x.seg = hex_tab[sh_val[idx*4 +: 4]];
        x.dp  = !sh_dp[idx];
        x.an  = ~(4'b0001 << idx);
      end else begin
        x.seg = 7'b1111111; x.dp = 1'b1; x.an = 4'b1111;
      end
    end
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (rst) begin
      k = 0; sh_val = '0; sh_dp = '0; sh_lit = '0;
    end else begin
      k++;
      if (ld) begin
        sh_val = v; sh_dp = d; sh_lit = lit;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  // lit = hand-computed set of slots that must light after blanking/LZB
  task automatic ld(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e,
                    input logic lz, input logic [3:0] lit);
    step(1'b0, 1'b1, v, d, e, lz, lit);
  endtask

  initial begin
    repeat (3) step(1'b1, 1'b1, 16'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 4'hF);
    idle(3);

    ld(16'h1234, 4'b0000, 4'b1111, 1'b0, 4'b1111);  idle(20);
    ld(16'hABCD, 4'b0000, 4'b1111, 1'b0, 4'b1111);  idle(16);
    ld(16'hEF09, 4'b0000, 4'b1111, 1'b0, 4'b1111);  idle(16);
    ld(16'h0070, 4'b0000, 4'b1111, 1'b1, 4'b0011);  idle(16);
    ld(16'h0000, 4'b0000, 4'b1111, 1'b1, 4'b0001);  idle(16);
    ld(16'h5555, 4'b1111, 4'b1010, 1'b0, 4'b1010);  idle(16);
    ld(16'h8600, 4'b0101, 4'b1111, 1'b1, 4'b1111);  idle(16);
    ld(16'h0300, 4'b1111, 4'b1011, 1'b1, 4'b0011);  idle(16);

    while ((k % CD) != CD - 1) idle(1);
    ld(16'h9876, 4'b0010, 4'b1111, 1'b0, 4'b1111);  idle(8);

    while ((k % CD) != 1) idle(1);
    step(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
    idle(6);
    ld(16'h4321, 4'b1000, 4'b1111, 1'b0, 4'b1111);  idle(8);

    repeat (2) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected outputs never compared, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
